// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM burst arbiter.
package rom_arb_pkg;

  // Width of the burst-length field (length minus one, 1..16 beats).
  localparam int LEN_W = 4;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter that streams bursts out of an external
// synchronous ROM (one-cycle read latency). One address is issued per ISSUE
// cycle; the matching data beat is flagged valid one cycle later, and the
// final beat lands in the single DRAIN cycle together with the done pulse.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [LEN_W-1:0]      len0,
  input  logic [LEN_W-1:0]      len1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]      LEN_ONE  = 1;
  localparam logic [LEN_W-1:0]      LEN_ZERO = 0;

  state_t                state;
  logic                  owner;        // 0: requester 0 owns the burst, 1: requester 1
  logic                  last_served;  // requester granted most recently
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LEN_W-1:0]      beats_left;

  logic                  any_req;
  logic                  pick;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [LEN_W-1:0]      pick_len;

  // The ROM data register is the read data; no extra pipeline stage.
  assign rdata = rom_q;

  // Round-robin pick: on contention favour whoever was not served last,
  // otherwise whoever is asking.
  always_comb begin
    any_req   = req0 | req1;
    pick      = (req0 & req1) ? ~last_served : req1;
    pick_addr = pick ? addr1 : addr0;
    pick_len  = pick ? len1 : len0;
  end

  // Burst sequencer: arbitrate in IDLE, walk addresses in ISSUE, flush in DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      addr_cnt    <= '0;
      beats_left  <= '0;
      rom_addr    <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-armed below.
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ISSUE;
            owner       <= pick;
            last_served <= pick;
            addr_cnt    <= pick_addr;
            rom_addr    <= pick_addr;
            beats_left  <= pick_len;
            gnt0        <= ~pick;
            gnt1        <= pick;
          end
        end
        ISSUE: begin
          // The address presented this cycle returns data next cycle.
          rvalid0  <= ~owner;
          rvalid1  <= owner;
          addr_cnt <= addr_cnt + ADDR_ONE;
          if (beats_left == LEN_ZERO) begin
            // Last address issued; rom_addr keeps it while idle.
            state <= DRAIN;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            beats_left <= beats_left - LEN_ONE;
            rom_addr   <= addr_cnt + ADDR_ONE;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ROM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, ROM address width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0 / req1  input  1  burst request from requester 0 / 1; level, held until granted.
REQ-006 addr0 / addr1  input  ADDR_WIDTH  burst start address, sampled with grant.
REQ-007 len0 / len1  input  4  burst length minus one (1..16 beats), sampled with grant.
REQ-008 gnt0 / gnt1  output  1  one-cycle pulse: request accepted.
REQ-009 rvalid0 / rvalid1  output  1  rdata valid for requester 0 / 1.
REQ-010 done0 / done1  output  1  pulse coincident with last rvalid of burst.
REQ-011 rdata  output  DATA_WIDTH  shared read data; equals rom_q.
REQ-012 rom_addr  output  ADDR_WIDTH  address to external synchronous ROM (1-cycle read latency).
REQ-013 rom_q  input  DATA_WIDTH  ROM registered read data.

Function
REQ-014 States IDLE, ISSUE, DRAIN; transitions only on clk rising edge.
REQ-015 IDLE: any req high -> ISSUE; latch owner, addr_cnt = addr_owner, beats_left = len_owner; gnt_owner = 1 for the first ISSUE cycle only.
REQ-016 Both req high in IDLE -> grant the requester not served last (round-robin); last-served pointer reset value = 1, so requester 0 wins first contention.
REQ-017 ISSUE: rom_addr = addr_cnt each cycle; on each edge addr_cnt += 1 modulo 2^ADDR_WIDTH (0xFF -> 0x00 at default), beats_left -= 1.
REQ-018 ISSUE with beats_left == 0 -> DRAIN on next edge.
REQ-019 DRAIN: exactly one cycle, then IDLE; no arbitration in ISSUE or DRAIN.
REQ-020 rvalid_owner asserted the cycle after each ISSUE cycle (registered); rdata = rom_q in that cycle; beat k carries ROM[start+k].
REQ-021 Grant-to-first-rvalid latency 1 cycle; burst of N beats occupies N ISSUE + 1 DRAIN cycles; minimum one IDLE cycle between bursts.
REQ-022 done_owner asserted only with the final rvalid (in DRAIN cycle).
REQ-023 Non-owner rvalid/done/gnt remain 0 throughout a burst.
REQ-024 req deasserted after grant: ignored, burst completes. req from owner during its burst: ignored until IDLE, then arbitrated normally.
REQ-025 addr/len changes after grant have no effect on active burst.
REQ-026 rom_addr holds last value outside ISSUE.

Reset
REQ-027 rst asserted: immediately state = IDLE; gnt*, rvalid*, done* = 0; rom_addr = 0; addr_cnt = 0; beats_left = 0; last-served = 1.
REQ-028 rst mid-burst: in-flight beats dropped, no done pulse; first IDLE cycle after rst release arbitrates fresh.

Structure
REQ-029 Package rom_arb_pkg holds state enum typedef (IDLE, ISSUE, DRAIN) and constant LEN_W = 4.
REQ-030 No sub-module required; round-robin select inline; ROM is instantiated beside the arbiter, not inside it.

Verification
REQ-031 Bench instantiates rom_arbiter with existing ROM preloaded rom[a] = ~a (8-bit).
REQ-032 Single: req0, addr0=0x10, len0=3 -> gnt0 1 cycle; rvalid0 next 4 cycles, rdata 0xEF,0xEE,0xED,0xEC; done0 with 0xEC; gnt1/rvalid1 stay 0.
REQ-033 Contention after reset: req0 & req1 same cycle -> requester 0 served first, then 1 after DRAIN + 1 IDLE; third simultaneous pair -> requester 0 again (alternation).
REQ-034 Wrap: req1, addr1=0xFE, len1=3 -> rdata 0x01,0x00,0xFF,0xFE; done1 on 0xFE.
REQ-035 Len 0: req0, addr0=0x55, len0=0 -> one rvalid0 with rdata 0xAA and done0 same cycle; IDLE two cycles after gnt0.
REQ-036 Reset mid-burst: req1, len1=15, rst after 5th beat -> all outputs 0 same cycle, no done1; post-release req0 granted normally.
